// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared FSM encodings and parameter range checks for adder_arbiter
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  function automatic bit num_req_ok(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response handshake bundle between clients and adder_arbiter
interface adder_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_sum;
  logic                 rsp_cout;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - 8-bit ripple-carry adder without carry-in
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       c_out
);
  logic [8:0] c;

  always_comb begin
    c = '0;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = c[8];
endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - combinational round-robin picker: first valid index at or after ptr
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Candidate index ptr+i folded back into 0..NUM_REQ-1
      k = {1'b0, ptr} + (ID_W+1)'(i);
      if (k >= (ID_W+1)'(NUM_REQ)) k = k - (ID_W+1)'(NUM_REQ);
      if (!any && req[k[ID_W-1:0]]) begin
        any = 1'b1;
        idx = k[ID_W-1:0];
      end
    end
    grant[idx] = any;
  end
endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one adder_8bit among NUM_REQ requesters
// Define ADDER_ARB_SAT_EN to saturate rsp_sum to 8'hFF on carry-out.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_arbiter_if.slave   bus
);
  if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
    $error("adder_arbiter: NUM_REQ out of range 2..8");
  end

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, op_id, gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_any, load_op, load_rsp, rsp_done;
  logic [7:0]          op_a, op_b, raw_sum, sum_out;
  logic                raw_cout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  adder_8bit u_add (
    .a     (op_a),
    .b     (op_b),
    .s     (raw_sum),
    .c_out (raw_cout)
  );

`ifdef ADDER_ARB_SAT_EN
  assign sum_out = raw_cout ? 8'hFF : raw_sum;
`else
  assign sum_out = raw_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_any) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_valid && bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    load_op       = 1'b0;
    load_rsp      = 1'b0;
    rsp_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = gnt;
        load_op       = gnt_any;
      end
      ST_EXEC: load_rsp = 1'b1;
      ST_RESP: rsp_done = bus.rsp_valid && bus.rsp_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
    end else begin
      if (load_op) begin
        op_a  <= bus.req_a[8*gnt_idx +: 8];
        op_b  <= bus.req_b[8*gnt_idx +: 8];
        op_id <= gnt_idx;
      end
      if (load_rsp) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= op_id;
        bus.rsp_sum   <= sum_out;
        bus.rsp_cout  <= raw_cout;
      end else if (rsp_done) begin
        bus.rsp_valid <= 1'b0;
        // The just-served requester drops to lowest priority
        rr_ptr <= (op_id == ID_W'(NUM_REQ-1)) ? '0 : op_id + 1'b1;
      end
    end
  end
endmodule
